// File: rtl/led_ctrl_pkg.sv
// led_reg_sched shared types
// FSM states, requester ids, register selects
package led_ctrl_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_PAT  = 1'b1;

  localparam logic SEL_REG1 = 1'b0;
  localparam logic SEL_REG2 = 1'b1;

  // counter width for a modulus n, never below 1 bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_reg_sched_if.sv
// led_reg_sched host write port
// req/ack handshake carrying a register select and data
interface led_reg_sched_if #(
  parameter int DW = 32
);
  logic          hst_req;
  logic          hst_sel;
  logic [DW-1:0] hst_data;
  logic          hst_ack;

  modport master (
    output hst_req,
    output hst_sel,
    output hst_data,
    input  hst_ack
  );

  modport slave (
    input  hst_req,
    input  hst_sel,
    input  hst_data,
    output hst_ack
  );
endinterface

// File: rtl/led_blink_timer.sv
// led blink engine timer
// period counter, pending request flag, overrun counter
module led_blink_timer
  import led_ctrl_pkg::*;
#(
  parameter int PERIOD = 100,
  parameter int OVR_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pat_en,
  input  logic             served,
  output logic             pending,
  output logic [OVR_W-1:0] ovr_cnt
);

  localparam int PW = cnt_w(PERIOD);
  localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

  logic [PW-1:0] cnt;
  logic          wrap;

  assign wrap = pat_en && (cnt == LAST);

  // period counter, parked at 0 while the engine is off
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (!pat_en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  // a fresh request on wrap wins over a same-edge service
  always_ff @(posedge CLK) begin
    if (RST || !pat_en) begin
      pending <= 1'b0;
    end else if (wrap) begin
      pending <= 1'b1;
    end else if (served) begin
      pending <= 1'b0;
    end
  end

  // wrap onto an unserved request loses it; count saturates
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovr_cnt <= '0;
    end else if (wrap && pending && !served
                 && (ovr_cnt != '1)) begin
      ovr_cnt <= ovr_cnt + OVR_W'(1);
    end
  end

endmodule

// File: rtl/led_reg_sched.sv
// led control register scheduler
// arbitrates host and blink engine writes, settles after each
module led_reg_sched
  import led_ctrl_pkg::*;
#(
  parameter int            DW         = 32,
  parameter int            PERIOD     = 100,
  parameter int            SETTLE_CYC = 4,
  parameter int            OVR_W      = 8,
  parameter logic [DW-1:0] RST_REG1   = '0,
  parameter logic [DW-1:0] RST_REG2   = '0
) (
  input  logic             CLK,
  input  logic             RST,
  led_reg_sched_if.slave   hst,
  input  logic             pat_en,
  input  logic [DW-1:0]    slv_reg0,
  output logic [DW-1:0]    slv_reg1,
  output logic [DW-1:0]    slv_reg2,
  output logic [DW-1:0]    sts_reg0,
  output logic             sts_chg,
  output logic             busy,
  output logic             pat_phase,
  output logic [OVR_W-1:0] ovr_cnt
);

  localparam int SW = cnt_w(SETTLE_CYC);
  localparam logic [SW-1:0] SLOAD = SW'(SETTLE_CYC - 1);

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] scnt;
  logic          rr_ptr;
  logic          pending;
  logic          can_gnt;
  logic          gnt_host;
  logic          gnt_pat;
  logic          gnt;
  logic          ack_q;
  logic          sts_vld;
  logic          chg_q;

  led_blink_timer #(
    .PERIOD (PERIOD),
    .OVR_W  (OVR_W)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .pat_en  (pat_en),
    .served  (gnt_pat),
    .pending (pending),
    .ovr_cnt (ovr_cnt)
  );

  // state register and settle countdown
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      scnt  <= '0;
    end else begin
      state <= state_nx;
      if (gnt) begin
        scnt <= SLOAD;
      end else if (scnt != '0) begin
        scnt <= scnt - SW'(1);
      end
    end
  end

  // next state: last settle cycle may re-grant or go idle
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (gnt) state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (gnt) state_nx = ST_SETTLE;
        else if (scnt == '0) state_nx = ST_IDLE;
      end
    endcase
  end

  // grant decode: round robin only on a tie
  always_comb begin
    busy     = (state == ST_SETTLE);
    can_gnt  = (state == ST_IDLE) || (scnt == '0);
    gnt_host = 1'b0;
    gnt_pat  = 1'b0;
    unique case (1'b1)
      can_gnt && hst.hst_req && pending: begin
        if (rr_ptr == REQ_HOST) gnt_pat = 1'b1;
        else gnt_host = 1'b1;
      end
      can_gnt && hst.hst_req && !pending:
        gnt_host = 1'b1;
      can_gnt && !hst.hst_req && pending:
        gnt_pat = 1'b1;
      default: ;
    endcase
    gnt = gnt_host || gnt_pat;
  end

  assign hst.hst_ack = ack_q;

  // register writes, ack pulse, phase and rr pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      slv_reg1  <= RST_REG1;
      slv_reg2  <= RST_REG2;
      pat_phase <= 1'b0;
      ack_q     <= 1'b0;
      rr_ptr    <= REQ_PAT;
    end else begin
      ack_q <= gnt_host;
      if (gnt_host) begin
        rr_ptr <= REQ_HOST;
        if (hst.hst_sel == SEL_REG1) begin
          slv_reg1  <= hst.hst_data;
          pat_phase <= hst.hst_data[0];
        end else begin
          slv_reg2 <= hst.hst_data;
        end
      end
      if (gnt_pat) begin
        rr_ptr      <= REQ_PAT;
        slv_reg1[0] <= ~slv_reg1[0];
        pat_phase   <= ~slv_reg1[0];
      end
    end
  end

  // status sample; change pulse lags the new value by a cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      sts_reg0 <= '0;
      sts_vld  <= 1'b0;
      chg_q    <= 1'b0;
      sts_chg  <= 1'b0;
    end else begin
      sts_reg0 <= slv_reg0;
      sts_vld  <= 1'b1;
      chg_q    <= sts_vld && (slv_reg0 != sts_reg0);
      sts_chg  <= chg_q;
    end
  end

endmodule

// File: tb/tb_led_reg_sched.sv
// led_reg_sched testbench
// vector table for host writes plus directed multi-cycle cases
module tb_led_reg_sched;
  import led_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  led_reg_sched_if #(.DW(32)) if_a ();
  led_reg_sched_if #(.DW(32)) if_b ();

  logic        pat_en_a, pat_en_b;
  logic [31:0] s0_a, s0_b;
  logic [31:0] r1_a, r1_b, r2_a, r2_b;
  logic [31:0] st_a, st_b;
  logic        chg_a, chg_b;
  logic        busy_a, busy_b;
  logic        ph_a, ph_b;
  logic [7:0]  ovr_a, ovr_b;

  led_reg_sched #(
    .DW(32), .PERIOD(100), .SETTLE_CYC(4), .OVR_W(8)
  ) dut_a (
    .CLK(CLK), .RST(RST), .hst(if_a),
    .pat_en(pat_en_a), .slv_reg0(s0_a),
    .slv_reg1(r1_a), .slv_reg2(r2_a),
    .sts_reg0(st_a), .sts_chg(chg_a),
    .busy(busy_a), .pat_phase(ph_a),
    .ovr_cnt(ovr_a)
  );

  led_reg_sched #(
    .DW(32), .PERIOD(2), .SETTLE_CYC(8), .OVR_W(8)
  ) dut_b (
    .CLK(CLK), .RST(RST), .hst(if_b),
    .pat_en(pat_en_b), .slv_reg0(s0_b),
    .slv_reg1(r1_b), .slv_reg2(r2_b),
    .sts_reg0(st_b), .sts_chg(chg_b),
    .busy(busy_b), .pat_phase(ph_b),
    .ovr_cnt(ovr_b)
  );

  typedef struct {
    logic        sel;
    logic [31:0] data;
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
    logic        exp_ph;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // one host write on dut_a: latency to ack, busy length
  task automatic host_wr(input logic sel,
                         input logic [31:0] d,
                         output int lat,
                         output int bcnt);
    if_a.hst_req  = 1'b1;
    if_a.hst_sel  = sel;
    if_a.hst_data = d;
    lat = 0;
    do begin
      step(1);
      lat++;
    end while (!if_a.hst_ack && lat < 20);
    if_a.hst_req = 1'b0;
    bcnt = 0;
    while (busy_a && bcnt < 20) begin
      bcnt++;
      step(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[5];
    int   lat, bc, n, pulses;
    logic prev;

    tv[0] = '{1'b1, 32'h0000_ffff, 32'h0, 32'h0000_ffff, 1'b0};
    tv[1] = '{1'b0, 32'h0000_0003, 32'h3, 32'h0000_ffff, 1'b1};
    tv[2] = '{1'b1, 32'hc100_0000, 32'h3, 32'hc100_0000, 1'b1};
    tv[3] = '{1'b0, 32'h0000_0010, 32'h10, 32'hc100_0000, 1'b0};
    tv[4] = '{1'b1, 32'h0000_ffff, 32'h10, 32'h0000_ffff, 1'b0};

    RST = 1'b1;
    pat_en_a = 1'b0; pat_en_b = 1'b0;
    s0_a = '0; s0_b = 32'h7;
    if_a.hst_req = 1'b0; if_a.hst_sel = 1'b0; if_a.hst_data = '0;
    if_b.hst_req = 1'b0; if_b.hst_sel = 1'b0; if_b.hst_data = '0;

    // reset state
    step(2);
    chk("rst r1", r1_a, 32'h0);
    chk("rst r2", r2_a, 32'h0);
    chk("rst ack", if_a.hst_ack, 1'b0);
    chk("rst busy", busy_a, 1'b0);
    chk("rst ovr", ovr_a, 8'h0);
    chk("rst phase", ph_a, 1'b0);
    chk("rst sts", st_a, 32'h0);
    chk("rst ovr b", ovr_b, 8'h0);
    RST = 1'b0;

    // first sample after reset differs from 0 but must not pulse
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (chg_b) pulses++;
    end
    chk("first sample no pulse", pulses, 0);
    chk("sts b value", st_b, 32'h7);

    // status change 0 -> 2 pulses once
    s0_a = 32'h2;
    step(1);
    chk("sts a value", st_a, 32'h2);
    chk("sts chg early", chg_a, 1'b0);
    step(1);
    chk("sts chg pulse", chg_a, 1'b1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (chg_a) pulses++;
    end
    chk("sts chg once", pulses, 0);

    // host write table
    for (int i = 0; i < 5; i++) begin
      host_wr(tv[i].sel, tv[i].data, lat, bc);
      chk($sformatf("v%0d ack lat", i), lat, 1);
      chk($sformatf("v%0d busy len", i), bc, 4);
      chk($sformatf("v%0d r1", i), r1_a, tv[i].exp_r1);
      chk($sformatf("v%0d r2", i), r2_a, tv[i].exp_r2);
      chk($sformatf("v%0d phase", i), ph_a, tv[i].exp_ph);
    end

    // back-to-back host writes, request held through
    if_a.hst_req  = 1'b1;
    if_a.hst_sel  = 1'b1;
    if_a.hst_data = 32'hc100_0000;
    n = 0;
    do begin step(1); n++; end
    while (!if_a.hst_ack && n < 20);
    chk("b2b ack1 lat", n, 1);
    chk("b2b r2 first", r2_a, 32'hc100_0000);
    if_a.hst_data = 32'h0000_ffff;
    n = 0;
    do begin step(1); n++; end
    while (!if_a.hst_ack && n < 20);
    chk("b2b ack gap", n, 4);
    chk("b2b r2 second", r2_a, 32'h0000_ffff);
    if_a.hst_req = 1'b0;
    step(5);

    // blink engine: first toggle 101 cycles after enable
    pat_en_a = 1'b1;
    prev = ph_a;
    n = 0;
    do begin step(1); n++; end
    while (ph_a == prev && n < 150);
    chk("blink first", n, 101);
    chk("blink r1 a", r1_a, 32'h11);
    chk("blink phase a", ph_a, r1_a[0]);
    prev = ph_a;
    n = 0;
    do begin step(1); n++; end
    while (ph_a == prev && n < 150);
    chk("blink period", n, 100);
    chk("blink r1 b", r1_a, 32'h10);
    chk("blink phase b", ph_a, r1_a[0]);

    // tie 1: pointer=engine, host wins, engine 4 later
    step(99);
    if_a.hst_req  = 1'b1;
    if_a.hst_sel  = 1'b0;
    if_a.hst_data = 32'h2;
    step(1);
    chk("tie1 host ack", if_a.hst_ack, 1'b1);
    chk("tie1 host r1", r1_a, 32'h2);
    if_a.hst_req = 1'b0;
    step(3);
    chk("tie1 no early eng", r1_a, 32'h2);
    step(1);
    chk("tie1 eng r1", r1_a, 32'h3);
    chk("tie1 eng phase", ph_a, 1'b1);

    // host-only write sets pointer=host before next wrap
    step(91);
    if_a.hst_req  = 1'b1;
    if_a.hst_sel  = 1'b1;
    if_a.hst_data = 32'h0000_00aa;
    step(1);
    chk("pre ack", if_a.hst_ack, 1'b1);
    chk("pre r2", r2_a, 32'h0000_00aa);
    if_a.hst_req = 1'b0;
    step(1);
    if_a.hst_req  = 1'b1;
    if_a.hst_sel  = 1'b0;
    if_a.hst_data = 32'h5;

    // tie 2: pointer=host, engine wins, host 4 later
    step(3);
    chk("tie2 eng r1", r1_a, 32'h2);
    chk("tie2 no ack", if_a.hst_ack, 1'b0);
    chk("tie2 eng phase", ph_a, 1'b0);
    step(4);
    chk("tie2 host ack", if_a.hst_ack, 1'b1);
    chk("tie2 final r1", r1_a, 32'h5);
    chk("tie2 final phase", ph_a, 1'b1);
    if_a.hst_req = 1'b0;
    pat_en_a = 1'b0;
    step(6);

    // overrun: PERIOD=2, SETTLE_CYC=8
    pat_en_b = 1'b1;
    step(3);
    chk("ovr first grant", ph_b, 1'b1);
    chk("ovr busy", busy_b, 1'b1);
    chk("ovr start", ovr_b, 8'd0);
    step(7);
    chk("ovr at 10", ovr_b, 8'd3);
    step(8);
    chk("ovr at 18", ovr_b, 8'd6);
    step(663);
    chk("ovr at 681", ovr_b, 8'd254);
    step(1);
    chk("ovr at 682", ovr_b, 8'd255);
    step(100);
    chk("ovr saturated", ovr_b, 8'd255);
    pat_en_b = 1'b0;
    step(2);

    // reset during SETTLE, held request re-arbitrated
    if_a.hst_req  = 1'b1;
    if_a.hst_sel  = 1'b1;
    if_a.hst_data = 32'h1234_5678;
    step(1);
    chk("mid ack", if_a.hst_ack, 1'b1);
    chk("mid busy", busy_a, 1'b1);
    RST = 1'b1;
    step(1);
    chk("mid rst busy", busy_a, 1'b0);
    chk("mid rst ack", if_a.hst_ack, 1'b0);
    chk("mid rst r2", r2_a, 32'h0);
    chk("mid rst r1", r1_a, 32'h0);
    chk("mid rst ovr b", ovr_b, 8'd0);
    RST = 1'b0;
    step(1);
    chk("rearb ack", if_a.hst_ack, 1'b1);
    chk("rearb r2", r2_a, 32'h1234_5678);
    if_a.hst_req = 1'b0;
    step(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
